mips_dmem_responder: RTL and testbench

// - Data-memory responder for the MIPS core. Serves the load/store requests that the core's MEM stage issues.
// - Valid/ready request channel in, one-cycle response pulse out. Configurable wait states.
// - Internal byte-enabled word RAM.
// - Replaces the ideal zero-wait memory, so the MIPS bench exercises stalls.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mips_dmem_array.sv | 34 +++
 rtl/mips_dmem_responder.sv | 137 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
//==============================================================================
// Module : mips_pkg
// Brief  : Shared widths, FSM states and error causes for the MIPS data memory.
// Rev    : 1.0 - initial release
//==============================================================================
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // Misalignment takes priority when both causes apply.
  function automatic logic [1:0] err_cause(input logic misaligned, input logic out_of_range);
    if (misaligned)        return ERR_MISALIGN;
    else if (out_of_range) return ERR_RANGE;
    else                   return ERR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_dmem_array.sv
`default_nettype none
//==============================================================================
// Module : mips_dmem_array
// Brief  : DEPTH x 32 word RAM, byte-enabled synchronous write, async read.
// Rev    : 1.0 - initial release
//==============================================================================
module mips_dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/mips_dmem_responder.sv
`default_nettype none
//==============================================================================
// Module : mips_dmem_responder
// Brief  : Valid/ready data-memory responder with LATENCY wait states.
// Rev    : 1.0 - initial release
//==============================================================================
module mips_dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_cur_we;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata;
  logic [BE_W-1:0]   w_cur_be;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [1:0]        w_err_cause;
  logic              w_err;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_rdata;

  assign req_ready = (r_state == ST_IDLE) & reset;
  assign w_accept  = req_valid & req_ready;

  // With zero wait states RESP is entered on the accept edge itself, before
  // the latch holds the request, so the live request feeds the datapath then.
  assign w_cur_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_cur_be    = (r_state == ST_IDLE) ? req_be    : r_be;

  assign w_misaligned   = |w_cur_addr[1:0];
  assign w_out_of_range = {2'b00, w_cur_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);
  assign w_err_cause    = err_cause(w_misaligned, w_out_of_range);
  assign w_err          = (w_err_cause != ERR_NONE);

  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
  assign w_ram_we     = w_enter_resp & w_cur_we & ~w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_cur_we | w_err) ? '0 : w_ram_rdata;
        r_err   <= w_err;
      end
    end
  end

  mips_dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_idx   (w_cur_addr[IDX_W+1:2]),
    .i_wdata (w_cur_wdata),
    .i_be    (w_cur_be),
    .o_rdata (w_ram_rdata)
  );

  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_responder.sv
`default_nettype none
//==============================================================================
// Module : tb_mips_dmem_responder
// Brief  : Directed and random transactions against a word-array memory model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_mips_dmem_responder;
  import mips_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        l0_valid = 1'b0, l0_we = 1'b0;
  logic        l0_ready;
  logic [31:0] l0_addr = '0, l0_wdata = '0;
  logic [3:0]  l0_be = '0;
  logic        l0_rvalid, l0_err;
  logic [31:0] l0_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [int];

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .ADDR_W(32)) dut_l0 (
    .clk(clk), .reset(reset), .req_valid(l0_valid), .req_ready(l0_ready),
    .req_we(l0_we), .req_addr(l0_addr), .req_wdata(l0_wdata), .req_be(l0_be),
    .resp_valid(l0_rvalid), .resp_rdata(l0_rdata), .resp_err(l0_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the LATENCY=2 instance; entered and left at a negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input string tag, output logic [31:0] rd);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] word;
    int          idx;
    int          n;
    int          lat;
    exp_err = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    idx     = int'(addr / 4);
    word    = (!exp_err && model.exists(idx)) ? model[idx] : 32'hxxxx_xxxx;
    exp_rd  = (exp_err || we) ? 32'h0 : word;

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    check({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    if (!$isunknown(exp_rd)) check({tag, "_rdata"}, resp_rdata, exp_rd);
    rd = resp_rdata;
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
      model[idx] = word;
    end
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] d1 [4];
    logic [31:0] a;
    int          nt;
    bit          acc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'b0, req_ready}, 32'd1);

    // Full-word store and load back
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "t2_st", rd);
    txn(1'b0, 32'h10, 32'h0, 4'h0, "t2_ld", rd);
    check("t2_const", rd, 32'hDEADBEEF);

    // Partial byte-enable store
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, "t3_st", rd);
    txn(1'b0, 32'h10, 32'h0, 4'hF, "t3_ld", rd);
    check("t3_const", rd, 32'hDE22BE44);

    // Misaligned and just-past-the-top addresses
    txn(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, "t4_mis", rd);
    txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, "t4_oor", rd);
    txn(1'b0, 32'h10, 32'h0, 4'h0, "t4_ld", rd);
    check("t4_const", rd, 32'hDE22BE44);
    txn(1'b1, 32'hFFC, 32'h5A5A_A5A5, 4'hF, "t4_top", rd);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0, "t4_topld", rd);

    // Reset during WAIT aborts the store
    txn(1'b1, 32'h20, 32'h0, 4'hF, "t5_zero", rd);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    check("t5_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_rvalid", {31'b0, resp_valid}, 32'd0);
      check("t5_rdy", {31'b0, req_ready}, 32'd0);
    end
    check("t5_rdata", resp_rdata, 32'd0);
    check("t5_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rel", {31'b0, req_ready}, 32'd1);
    check("t5_norsp", {31'b0, resp_valid}, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, "t5_ld", rd);
    check("t5_const", rd, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        7:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        8:       a = ($urandom_range(0, 1) != 0) ? 32'(4 * DEPTH) : 32'(4 * DEPTH - 4);
        9:       a = $urandom | 32'h0000_1000;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      txn(1'($urandom), a, $urandom, 4'($urandom), "rnd", rd);
    end

    // Zero-latency instance, valid held high: 4 stores then 4 loads
    for (int t = 0; t < 4; t++) d1[t] = $urandom;
    nt = 0;
    l0_valid = 1'b1; l0_we = 1'b1; l0_addr = 32'h0; l0_wdata = d1[0]; l0_be = 4'hF;
    for (int c = 0; c < 16; c++) begin
      check("l0_ready", {31'b0, l0_ready}, 32'(c % 2 == 0));
      check("l0_rvalid", {31'b0, l0_rvalid}, 32'(c % 2 == 1));
      if (l0_rvalid) begin
        check("l0_err", {31'b0, l0_err}, 32'd0);
        check("l0_rdata", l0_rdata, ((c - 1) / 2 < 4) ? 32'h0 : d1[(c - 1) / 2 - 4]);
      end
      acc = l0_ready;
      @(negedge clk);
      if (acc) begin
        nt++;
        if (nt < 8) begin
          l0_we    = (nt < 4);
          l0_addr  = 32'((nt % 4) * 4);
          l0_wdata = (nt < 4) ? d1[nt] : $urandom;
          l0_be    = (nt < 4) ? 4'hF : 4'($urandom);
        end else begin
          l0_valid = 1'b0;
        end
      end
    end
    check("l0_done", 32'(nt), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
